// File: rtl/pipes.sv
// Shared types for the fetch front end.
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : one buffered entry handed to decode {pc, raw_instr, exc}
//   PC_RESET_DEFAULT : default first fetch address after reset
package pipes;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch_entry_t between the fetch FSM and decode.
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : synchronous clear, wins over push and pop
//   push, entry : write one entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head        : registered head entry
//   count       : number of valid entries
module fetch_fifo
  import pipes::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign do_push = push && (count_q < CntW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= entry;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word request at a time on
// the instruction bus and buffers {pc, raw_instr, exc} for decode.
//   clk, resetn            : clock, asynchronous active-low reset
//   ireq_valid/ireq_addr   : bus request, held stable until iresp_data_ok
//   iresp_addr_ok          : informational, unused
//   iresp_data_ok/_data    : read data, completes the request
//   redirect_valid/_pc     : taken branch/jump from execute, flushes the buffer
//   out_valid/out_ready    : handshake to decode
//   out_pc/out_raw_instr   : head entry
//   out_exc                : misaligned-fetch marker
// Optional feature macro: FETCH_MISALIGN_EXC_EN. When defined a misaligned PC
// produces an exception entry and halts fetch until the next redirect; otherwise
// the PC is forced aligned and out_exc is tied low.
module fetch_unit
  import pipes::*;
#(
  parameter logic [63:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_raw_instr,
  output logic        out_exc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     pc_al;
  logic            push, pop, space;
  fetch_entry_t    push_entry, head;
  logic [CntW-1:0] count;

  logic unused_addr_ok;
  assign unused_addr_ok = iresp_addr_ok;

  assign pc_al = {pc_q[63:2], 2'b00};
  // Space is judged on registered occupancy, so a pop frees a slot next cycle.
  assign space = count < CntW'(FIFO_DEPTH);
  assign pop   = out_valid && out_ready;

`ifdef FETCH_MISALIGN_EXC_EN
  logic halt_q, halt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) halt_q <= 1'b0;
    else         halt_q <= halt_d;
  end
`else
  logic [1:0] unused_pc_lo;
  assign unused_pc_lo = pc_q[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    push_entry = '0;
`ifdef FETCH_MISALIGN_EXC_EN
    halt_d     = redirect_valid ? 1'b0 : halt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (space) begin
`ifdef FETCH_MISALIGN_EXC_EN
          if (pc_q[1:0] != 2'b00) begin
            if (!halt_q) begin
              push       = 1'b1;
              push_entry = '{pc: pc_q, raw_instr: 32'h0, exc: 1'b1};
              halt_d     = 1'b1;
            end
          end else begin
            state_d = REQ;
            addr_d  = pc_q;
          end
`else
          state_d = REQ;
          addr_d  = pc_al;
`endif
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = iresp_data_ok ? IDLE : DISCARD;
        end else if (iresp_data_ok) begin
          push       = 1'b1;
          push_entry = '{pc: pc_al, raw_instr: iresp_data, exc: 1'b0};
          pc_d       = pc_al + 64'd4;
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (iresp_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .flush (redirect_valid),
    .push  (push),
    .entry (push_entry),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign ireq_valid    = (state_q != IDLE);
  assign ireq_addr     = addr_q;
  assign out_valid     = (count != '0);
  assign out_pc        = head.pc;
  assign out_raw_instr = head.raw_instr;
`ifdef FETCH_MISALIGN_EXC_EN
  assign out_exc       = head.exc;
`else
  logic unused_head_exc;
  assign unused_head_exc = head.exc;
  assign out_exc         = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: owns the PC, issues word requests on the instruction bus, and delivers `{pc, raw_instr}` to the decode stage through a small output FIFO with a valid/ready handshake. It is the producer side of the raw-instruction interface that decode consumes. It accepts branch/jump redirects from execute and discards stale in-flight and buffered instructions.

## Interface
Parameters:
- `PC_RESET`, 64'h8000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, 2: output buffer entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `resetn`  in  1  asynchronous active-low reset.
- `ireq_valid`  out  1  instruction bus request valid.
- `ireq_addr`  out  64  request address, word aligned.
- `iresp_addr_ok`  in  1  bus accepted the address.
- `iresp_data_ok`  in  1  read data valid; completes the request.
- `iresp_data`  in  32  instruction word.
- `redirect_valid`  in  1  execute resolved a taken branch or jump.
- `redirect_pc`  in  64  new fetch target.
- `out_valid`  out  1  head entry valid to decode.
- `out_ready`  in  1  decode accepts the head entry.
- `out_pc`  out  64  PC of the head entry.
- `out_raw_instr`  out  32  instruction of the head entry.
- `out_exc`  out  1  head entry is a misaligned-fetch marker. Tied to 0 when the configuration feature is off.

## Operation
- At most one outstanding bus request.
- `ireq_valid` and `ireq_addr` stay stable from assertion until `iresp_data_ok`. `iresp_addr_ok` is informational only. `iresp_addr_ok` and `iresp_data_ok` in the same cycle is legal.
- A request is issued only when `fifo_count < FIFO_DEPTH`. The in-flight request counts as one occupied slot.
- FSM states:
  - IDLE: no request in flight. Issue at `pc` when there is space → REQ.
  - REQ: waiting for `iresp_data_ok`. On data_ok, push `{pc, iresp_data, 0}` and set `pc += 4` → IDLE. The bus may return in the same cycle; the FSM reaches IDLE and can re-issue on the next cycle.
  - DISCARD: request still held on the bus, but its data is stale. On data_ok, drop the data → IDLE.
- Redirect handling (all flush the FIFO the same cycle; `pc <= redirect_pc`):
  - In IDLE: FSM stays in IDLE; the request at the new PC issues the next cycle.
  - In REQ without data_ok: → DISCARD.
  - In REQ with data_ok in the same cycle: data dropped → IDLE.
  - In DISCARD: target updated; stay in DISCARD.
- Redirect takes priority over a same-cycle push and a same-cycle pop.
- A pop happens when `out_valid && out_ready`. The freed slot permits a new request on the next cycle.
- All PC arithmetic is 64-bit and wraps modulo 2^64 with no flag.

## Timing
- Reset values: `ireq_valid`=0, `ireq_addr`=0, `out_valid`=0, `out_pc`=0, `out_raw_instr`=0, `out_exc`=0. Internal state: `pc`=`PC_RESET`, FSM in IDLE, FIFO empty.
- First `ireq_valid` is asserted in the first clock edge after `resetn` deasserts, with `ireq_addr`=`PC_RESET`.
- Latency: `iresp_data_ok` in cycle N gives `out_valid` in cycle N+1. Outputs are registered; there is no bypass.
- Redirect in cycle N: `out_valid`=0 in N+1. The new-target request is at the earliest in N+1 from IDLE; from DISCARD it follows the stale data_ok.
- Asserting `resetn` low mid-request drops everything asynchronously. The bus is expected to be reset together with this block.
- Sustained throughput: one instruction per two cycles with a zero-wait bus (request cycle, then IDLE cycle).

## Configuration
- `FETCH_MISALIGN_EXC_EN` defined:
  - When `pc[1:0]!=0` in IDLE, no bus request is issued.
  - Instead, push `{pc, 32'h0, 1}` when space is available, then stop fetching until a redirect arrives.
- `FETCH_MISALIGN_EXC_EN` undefined:
  - `ireq_addr` uses `{pc[63:2], 2'b00}`; `out_pc` carries the forced-aligned value.
  - `out_exc` is constant 0.

## Structure
- Package `pipes`:
  - `fetch_state_t` enum: IDLE, REQ, DISCARD.
  - `fetch_entry_t` struct: `pc`, `raw_instr`, `exc`.
  - `PC_RESET` default constant.
- Sub-module `fetch_fifo`: a parameterised FIFO of `fetch_entry_t` with push, pop, synchronous flush and count.
  - Flush has priority over push and pop.
  - Push is ignored when full; the FSM guarantees this never happens.

## Test plan
- Reset release with a zero-wait bus (data_ok in the request cycle) and `out_ready`=1 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008. Out entries appear one cycle after each data_ok.
- `out_ready`=0 held → exactly `FIFO_DEPTH` entries buffered and `ireq_valid` stays 0. Raising `out_ready` for one cycle → one new request on the next cycle.
- Bus data_ok delayed 3 cycles with redirect to 0x8000_1000 in wait cycle 1 → `ireq_addr` held at the old address until data_ok. That data is not output; the next request is at 0x8000_1000.
- Redirect, data_ok and pop in the same cycle with a full FIFO → FIFO empty next cycle, data dropped, next request at the redirect target.
- Redirect to 0x8000_0002:
  - With `FETCH_MISALIGN_EXC_EN`: no request; entry {0x8000_0002, 0, exc=1}; fetch halts until the next redirect.
  - Without it: request at 0x8000_0000.
- PC 0xFFFF_FFFF_FFFF_FFFC fetched → next request at 0x0. `resetn` low mid-request → all outputs 0 immediately.
